// File: rtl/rv32_pkg.sv
// Shared RV32I control definitions: opcodes, ALU/branch encodings and the
// decoded control bundle passed from the decoder to the sequencer.
package rv32_pkg;
  typedef enum logic [2:0] {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J} inst_type;

  typedef enum logic [3:0] {
    FOP_ADD = 4'd0, FOP_SUB = 4'd1, FOP_AND = 4'd2, FOP_OR  = 4'd3,
    FOP_XOR = 4'd4, FOP_SLL = 4'd5, FOP_SRL = 4'd6, FOP_SRA = 4'd7,
    FOP_IMM = 4'd8, FOP_SLT = 4'd9, FOP_SLTU = 4'd10
  } fop_t;

  typedef enum logic [2:0] {
    NONE = 3'd0, BEQ = 3'd1, BNE = 3'd2, BLT = 3'd3,
    BGE = 3'd4, BLTU = 3'd5, BGEU = 3'd6
  } b_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] MSZ_BYTE = 2'd0;
  localparam logic [1:0] MSZ_HALF = 2'd1;
  localparam logic [1:0] MSZ_WORD = 2'd2;

  typedef struct packed {
    fop_t       alu_op;
    b_t         branch_type;
    logic       reg_write_en;
    logic       alu_mux_en;
    logic       pc_absolute_jump_vec;
    logic       read_next_pc;
    logic       is_load;
    logic       is_store;
    logic [1:0] mem_size;
    logic       load_unsigned;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{alu_op: FOP_ADD, branch_type: NONE,
    reg_write_en: 1'b0, alu_mux_en: 1'b0, pc_absolute_jump_vec: 1'b0,
    read_next_pc: 1'b0, is_load: 1'b0, is_store: 1'b0,
    mem_size: MSZ_BYTE, load_unsigned: 1'b0};

  // funct7[5] only distinguishes sub (register form) and sra/srai.
  function automatic fop_t alu_fn(input logic [2:0] f3, input logic alt,
                                  input logic is_reg);
    case (f3)
      3'b000:  alu_fn = (alt && is_reg) ? FOP_SUB : FOP_ADD;
      3'b001:  alu_fn = FOP_SLL;
      3'b010:  alu_fn = FOP_SLT;
      3'b011:  alu_fn = FOP_SLTU;
      3'b100:  alu_fn = FOP_XOR;
      3'b101:  alu_fn = alt ? FOP_SRA : FOP_SRL;
      3'b110:  alu_fn = FOP_OR;
      default: alu_fn = FOP_AND;
    endcase
  endfunction
endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I decode: instruction word -> control bundle + illegal flag.
module control_decoder
  import rv32_pkg::*;
#(
  parameter int SUPPORT_HALF = 1
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal
);
  logic [2:0] f3;
  logic       alt;
  logic       half_ok;
  logic       unused_bits;

  assign f3          = inst[14:12];
  assign alt         = inst[30];
  assign half_ok     = (SUPPORT_HALF != 0);
  assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_op       = alu_fn(f3, alt, 1'b1);
      end
      OPC_OP_IMM: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_mux_en   = 1'b1;
        ctrl.alu_op       = alu_fn(f3, alt, 1'b0);
      end
      OPC_LUI: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_mux_en   = 1'b1;
        ctrl.alu_op       = FOP_IMM;
      end
      OPC_AUIPC: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_mux_en   = 1'b1;
      end
      OPC_JAL: begin
        ctrl.reg_write_en = 1'b1;
        ctrl.read_next_pc = 1'b1;
      end
      OPC_JALR: begin
        illegal                   = (f3 != 3'b000);
        ctrl.reg_write_en         = 1'b1;
        ctrl.read_next_pc         = 1'b1;
        ctrl.pc_absolute_jump_vec = 1'b1;
        ctrl.alu_mux_en           = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_op = FOP_SUB;
        case (f3)
          3'b000:  ctrl.branch_type = BEQ;
          3'b001:  ctrl.branch_type = BNE;
          3'b100:  ctrl.branch_type = BLT;
          3'b101:  ctrl.branch_type = BGE;
          3'b110:  ctrl.branch_type = BLTU;
          3'b111:  ctrl.branch_type = BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.is_load       = 1'b1;
        ctrl.alu_mux_en    = 1'b1;
        ctrl.load_unsigned = f3[2];
        case (f3)
          3'b000, 3'b100: ctrl.mem_size = MSZ_BYTE;
          3'b001, 3'b101: begin
            ctrl.mem_size = MSZ_HALF;
            illegal       = !half_ok;
          end
          3'b010:  ctrl.mem_size = MSZ_WORD;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.is_store   = 1'b1;
        ctrl.alu_mux_en = 1'b1;
        case (f3)
          3'b000: ctrl.mem_size = MSZ_BYTE;
          3'b001: begin
            ctrl.mem_size = MSZ_HALF;
            illegal       = !half_ok;
          end
          3'b010:  ctrl.mem_size = MSZ_WORD;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // An illegal word must never leak write or memory enables downstream.
    if (illegal) ctrl = CTRL_NOP;
  end
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I control FSM: accepts one instruction at a time, drives
// registered datapath controls and times out stalled memory accesses.
module control_sequencer
  import rv32_pkg::*;
#(
  parameter int WAIT_MAX     = 15,
  parameter int SUPPORT_HALF = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  input  logic        mem_ack,
  output logic [3:0]  alu_op,
  output logic [2:0]  branch_type,
  output logic        reg_write_en,
  output logic        alu_mux_en,
  output logic        mem_to_reg,
  output logic        pc_absolute_jump_vec,
  output logic        read_next_pc,
  output logic        read_mem,
  output logic        write_mem,
  output logic [1:0]  mem_size,
  output logic        load_unsigned,
  output logic        pc_en,
  output logic        illegal_inst,
  output logic        mem_fault
);
  typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, FAULT} state_t;

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  ctrl_t         dec;
  logic          dec_illegal;
  logic          ld_q, st_q, lu_q;
  logic [1:0]    msz_q;

  fop_t       alu_op_d;
  b_t         branch_d;
  logic       rw_d, mux_d, m2r_d, abs_d, rnp_d, rd_d, wr_d, lu_d, pc_d, ill_d, flt_d;
  logic [1:0] msz_d;

  control_decoder #(.SUPPORT_HALF(SUPPORT_HALF)) u_dec (
    .inst    (inst),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );

  assign inst_ready = (state == IDLE) && nrst;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      ld_q  <= 1'b0;
      st_q  <= 1'b0;
      lu_q  <= 1'b0;
      msz_q <= MSZ_BYTE;
      alu_op <= FOP_ADD;
      branch_type <= NONE;
      {reg_write_en, alu_mux_en, mem_to_reg, pc_absolute_jump_vec, read_next_pc} <= '0;
      {read_mem, write_mem, load_unsigned, pc_en, illegal_inst, mem_fault} <= '0;
      mem_size <= MSZ_BYTE;
    end else begin
      state <= state_d;
      if (state == IDLE && inst_valid) begin
        ld_q  <= dec.is_load;
        st_q  <= dec.is_store;
        lu_q  <= dec.load_unsigned;
        msz_q <= dec.mem_size;
      end
      if (state == EXEC) cnt <= '0;
      else if (state == MEM && !mem_ack && cnt != CNT_MAX) cnt <= cnt + CW'(1);
      alu_op               <= alu_op_d;
      branch_type          <= branch_d;
      reg_write_en         <= rw_d;
      alu_mux_en           <= mux_d;
      mem_to_reg           <= m2r_d;
      pc_absolute_jump_vec <= abs_d;
      read_next_pc         <= rnp_d;
      read_mem             <= rd_d;
      write_mem            <= wr_d;
      mem_size             <= msz_d;
      load_unsigned        <= lu_d;
      pc_en                <= pc_d;
      illegal_inst         <= ill_d;
      mem_fault            <= flt_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (inst_valid) state_d = EXEC;
      EXEC:  state_d = (ld_q || st_q) ? MEM : IDLE;
      MEM: begin
        if (mem_ack)             state_d = ld_q ? WB : IDLE;
        else if (cnt == CNT_MAX) state_d = FAULT;
      end
      WB:      state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Values computed here land in the output registers on the same edge as
  // state_d, so they describe the cycle spent in the next state.
  always_comb begin
    alu_op_d = FOP_ADD;
    branch_d = NONE;
    {rw_d, mux_d, m2r_d, abs_d, rnp_d, rd_d, wr_d, lu_d, pc_d, ill_d, flt_d} = '0;
    msz_d = MSZ_BYTE;
    case (state)
      IDLE: if (inst_valid) begin
        if (dec_illegal) begin
          ill_d = 1'b1;
          pc_d  = 1'b1;
        end else if (dec.is_load || dec.is_store) begin
          mux_d = 1'b1;
          msz_d = dec.mem_size;
          lu_d  = dec.load_unsigned;
        end else begin
          alu_op_d = dec.alu_op;
          branch_d = dec.branch_type;
          rw_d     = dec.reg_write_en;
          mux_d    = dec.alu_mux_en;
          abs_d    = dec.pc_absolute_jump_vec;
          rnp_d    = dec.read_next_pc;
          pc_d     = 1'b1;
        end
      end
      EXEC: if (ld_q || st_q) begin
        rd_d  = ld_q;
        wr_d  = st_q;
        mux_d = 1'b1;
        msz_d = msz_q;
        lu_d  = lu_q;
      end
      MEM: begin
        if (mem_ack) begin
          pc_d  = 1'b1;
          rw_d  = ld_q;
          m2r_d = ld_q;
          msz_d = ld_q ? msz_q : MSZ_BYTE;
          lu_d  = ld_q && lu_q;
        end else if (cnt == CNT_MAX) begin
          flt_d = 1'b1;
        end else begin
          rd_d  = ld_q;
          wr_d  = st_q;
          mux_d = 1'b1;
          msz_d = msz_q;
          lu_d  = lu_q;
        end
      end
      FAULT:   flt_d = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed expectations per vector.
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        nrst;
  logic        inst_valid;
  logic [31:0] inst;
  logic        mem_ack;

  logic       inst_ready, reg_write_en, alu_mux_en, mem_to_reg, abs_jmp, read_next_pc;
  logic       read_mem, write_mem, load_unsigned, pc_en, illegal_inst, mem_fault;
  logic [3:0] alu_op;
  logic [2:0] branch_type;
  logic [1:0] mem_size;

  logic       nh_inst_ready, nh_reg_write_en, nh_alu_mux_en, nh_mem_to_reg, nh_abs_jmp;
  logic       nh_read_next_pc, nh_read_mem, nh_write_mem, nh_load_unsigned, nh_pc_en;
  logic       nh_illegal_inst, nh_mem_fault;
  logic [3:0] nh_alu_op;
  logic [2:0] nh_branch_type;
  logic [1:0] nh_mem_size;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_sequencer #(.WAIT_MAX(15), .SUPPORT_HALF(1)) dut (
    .clk(clk), .nrst(nrst), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .mem_ack(mem_ack), .alu_op(alu_op),
    .branch_type(branch_type), .reg_write_en(reg_write_en),
    .alu_mux_en(alu_mux_en), .mem_to_reg(mem_to_reg),
    .pc_absolute_jump_vec(abs_jmp), .read_next_pc(read_next_pc),
    .read_mem(read_mem), .write_mem(write_mem), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .pc_en(pc_en),
    .illegal_inst(illegal_inst), .mem_fault(mem_fault)
  );

  control_sequencer #(.WAIT_MAX(15), .SUPPORT_HALF(0)) dut_nh (
    .clk(clk), .nrst(nrst), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(nh_inst_ready), .mem_ack(mem_ack), .alu_op(nh_alu_op),
    .branch_type(nh_branch_type), .reg_write_en(nh_reg_write_en),
    .alu_mux_en(nh_alu_mux_en), .mem_to_reg(nh_mem_to_reg),
    .pc_absolute_jump_vec(nh_abs_jmp), .read_next_pc(nh_read_next_pc),
    .read_mem(nh_read_mem), .write_mem(nh_write_mem), .mem_size(nh_mem_size),
    .load_unsigned(nh_load_unsigned), .pc_en(nh_pc_en),
    .illegal_inst(nh_illegal_inst), .mem_fault(nh_mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle instruction: accept, check EXEC controls, check return to IDLE.
  task automatic exec_one(input string tag, input logic [31:0] w, input logic [3:0] e_alu,
                          input logic [2:0] e_br, input logic e_rw, input logic e_rnp,
                          input logic e_abs, input logic e_ill);
    inst = w; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk({tag, ".alu"}, alu_op, e_alu);
    chk({tag, ".br"},  branch_type, e_br);
    chk({tag, ".rw"},  reg_write_en, e_rw);
    chk({tag, ".rnp"}, read_next_pc, e_rnp);
    chk({tag, ".abs"}, abs_jmp, e_abs);
    chk({tag, ".ill"}, illegal_inst, e_ill);
    chk({tag, ".pc"},  pc_en, 1);
    chk({tag, ".mem"}, {read_mem, write_mem}, 0);
    chk({tag, ".rdy_exec"}, inst_ready, 0);
    tick();
    chk({tag, ".rdy_idle"}, inst_ready, 1);
    chk({tag, ".pc_idle"}, pc_en, 0);
  endtask

  initial begin
    nrst = 1'b0; inst_valid = 1'b0; inst = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst.ready", inst_ready, 0);
    chk("rst.outs", {pc_en, reg_write_en, read_mem, write_mem, illegal_inst, mem_fault}, 0);
    chk("rst.alu", alu_op, 0);
    chk("rst.br", branch_type, 0);
    nrst = 1'b1; #1;
    chk("rst.ready_rel", inst_ready, 1);

    exec_one("add",   32'h002081B3, 4'd0,  3'd0, 1, 0, 0, 0);
    exec_one("sub",   32'h402081B3, 4'd1,  3'd0, 1, 0, 0, 0);
    exec_one("sra",   32'h4020D1B3, 4'd7,  3'd0, 1, 0, 0, 0);
    exec_one("sltu",  32'h0020B1B3, 4'd10, 3'd0, 1, 0, 0, 0);
    exec_one("slti",  32'h0050A193, 4'd9,  3'd0, 1, 0, 0, 0);
    exec_one("srli",  32'h0010D193, 4'd6,  3'd0, 1, 0, 0, 0);
    exec_one("srai",  32'h4010D193, 4'd7,  3'd0, 1, 0, 0, 0);
    exec_one("lui",   32'h000011B7, 4'd8,  3'd0, 1, 0, 0, 0);
    exec_one("jal",   32'h000000EF, 4'd0,  3'd0, 1, 1, 0, 0);
    exec_one("jalr",  32'h000100E7, 4'd0,  3'd0, 1, 1, 1, 0);
    exec_one("beq",   32'h00208463, 4'd1,  3'd1, 0, 0, 0, 0);
    exec_one("bltu",  32'h0020E463, 4'd1,  3'd5, 0, 0, 0, 0);
    exec_one("zero",  32'h00000000, 4'd0,  3'd0, 0, 0, 0, 1);
    exec_one("badbr", 32'h0020A463, 4'd0,  3'd0, 0, 0, 0, 1);

    // lw acked in its third MEM cycle
    inst = 32'h0000A183; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0;
    chk("lw.exec_rd", read_mem, 0);
    chk("lw.exec_pc", pc_en, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("lw.mem%0d_rd", i), read_mem, 1);
      chk($sformatf("lw.mem%0d_sz", i), mem_size, 2);
      chk($sformatf("lw.mem%0d_pc", i), pc_en, 0);
    end
    chk("lw.mem_mux", alu_mux_en, 1);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("lw.wb_rd", read_mem, 0);
    chk("lw.wb_ctl", {reg_write_en, mem_to_reg, pc_en}, 3'b111);
    chk("lw.wb_rdy", inst_ready, 0);
    tick();
    chk("lw.idle_rdy", inst_ready, 1);
    chk("lw.idle_ctl", {reg_write_en, mem_to_reg, pc_en}, 0);

    // lh: legal load on dut, illegal on the half-less variant
    inst = 32'h00109183; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0;
    chk("lh_nh.ill", nh_illegal_inst, 1);
    chk("lh_nh.pc", nh_pc_en, 1);
    chk("lh.ill", illegal_inst, 0);
    tick();
    chk("lh_nh.rd", nh_read_mem, 0);
    chk("lh_nh.ill_drop", nh_illegal_inst, 0);
    chk("lh.rd", read_mem, 1);
    chk("lh.sz", mem_size, 1);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("lh.wb", {reg_write_en, mem_to_reg, pc_en}, 3'b111);
    tick();

    // sw acked in first MEM cycle: pc pulse with no register write
    inst = 32'h0030A023; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0;
    tick();
    chk("sw.wr", write_mem, 1);
    chk("sw.rd", read_mem, 0);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("sw.pc", pc_en, 1);
    chk("sw.wr_drop", write_mem, 0);
    chk("sw.rw", reg_write_en, 0);
    chk("sw.rdy", inst_ready, 1);
    tick();

    // reset during MEM of lw
    inst = 32'h0000A183; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0;
    tick();
    chk("rmem.rd", read_mem, 1);
    nrst = 1'b0; #1;
    chk("rmem.rdy_low", inst_ready, 0);
    tick();
    chk("rmem.rd_drop", read_mem, 0);
    chk("rmem.pc", pc_en, 0);
    tick();
    chk("rmem.pc2", pc_en, 0);
    nrst = 1'b1; #1;
    chk("rmem.rdy", inst_ready, 1);

    // sw never acked: 16 MEM cycles then FAULT
    inst = 32'h0030A023; inst_valid = 1'b1;
    tick(); inst_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to.mem%0d_wr", i), write_mem, 1);
      chk($sformatf("to.mem%0d_flt", i), mem_fault, 0);
    end
    tick();
    chk("to.flt", mem_fault, 1);
    chk("to.wr", write_mem, 0);
    chk("to.rdy", inst_ready, 0);
    inst = 32'h002081B3; inst_valid = 1'b1;
    tick(); tick();
    chk("to.flt_hold", mem_fault, 1);
    chk("to.en", {pc_en, reg_write_en, read_mem, write_mem}, 0);
    chk("to.rdy_hold", inst_ready, 0);
    inst_valid = 1'b0;
    nrst = 1'b0;
    tick();
    chk("to.flt_clr", mem_fault, 0);
    nrst = 1'b1; #1;
    chk("to.rdy_rel", inst_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
